// File: rtl/pid_pkg.sv
// Shared types, output range helpers and a symmetric clamp for the PID controller family.
package pid_pkg;
  localparam int PID_WIDTH = 16;

  typedef logic signed [63:0] wide_t;

  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic wide_t out_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t out_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  localparam wide_t OUT_MAX = out_max(PID_WIDTH);
  localparam wide_t OUT_MIN = out_min(PID_WIDTH);

  function automatic wide_t sat_clamp(input wide_t value, input wide_t limit);
    wide_t r;
    r = value;
    if (value > limit) r = limit;
    else if (value < -limit) r = -limit;
    return r;
  endfunction
endpackage

// File: rtl/pid_controller_mc_sat.sv
// Combinational floor shift by FRAC then saturation of a wide signed sum to WIDTH bits.
// Zero latency; no handshake, hi/lo flags report which rail was hit.
module pid_sat
  import pid_pkg::*;
#(
  parameter int    IN_W  = 50,
  parameter int    WIDTH = PID_WIDTH,
  parameter int    FRAC  = 8,
  parameter wide_t MAX_V = OUT_MAX,
  parameter wide_t MIN_V = OUT_MIN
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [WIDTH-1:0] result,
  output logic                    sat_hi,
  output logic                    sat_lo
);
  logic signed [IN_W-1:0] shifted;
  wide_t                  shifted_w;

  always_comb begin
    shifted   = sum >>> FRAC;
    shifted_w = wide_t'(shifted);
    sat_hi    = shifted_w > MAX_V;
    sat_lo    = shifted_w < MIN_V;
    if (sat_hi)      result = WIDTH'(MAX_V);
    else if (sat_lo) result = WIDTH'(MIN_V);
    else             result = shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed PID for CH channels: 3-cycle latency, one sample per cycle across channels.
// No output backpressure; in_ready drops only while the same channel is still in flight.
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int     WIDTH   = PID_WIDTH,
  parameter int     CH      = 4,
  parameter int     GAIN_W  = 16,
  parameter int     FRAC    = 8,
  parameter int     ACC_W   = 32,
  parameter longint INT_LIM = 64'sd1 << 20,
  localparam int    CH_W    = ch_width(CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [WIDTH-1:0]  setpoint,
  input  logic signed [WIDTH-1:0]  feedback,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic signed [GAIN_W-1:0] kd,
  input  logic                     clear_en,
  input  logic [CH_W-1:0]          clear_ch,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [WIDTH-1:0]  control_out,
  output logic [1:0]               out_sat
);
  localparam int E_W   = WIDTH + 1;
  localparam int D_W   = WIDTH + 2;
  localparam int PE_W  = GAIN_W + E_W;
  localparam int PI_W  = GAIN_W + ACC_W;
  localparam int PD_W  = GAIN_W + D_W;
  localparam int SUM_W = ACC_W + GAIN_W + 2;
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [E_W-1:0]    e;
    logic [ACC_W-1:0]  i;
    logic [D_W-1:0]    d;
    logic [GAIN_W-1:0] kp;
    logic [GAIN_W-1:0] ki;
    logic [GAIN_W-1:0] kd;
  } s1_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [PE_W-1:0] p;
    logic [PI_W-1:0] i;
    logic [PD_W-1:0] d;
  } s2_t;

  logic signed [ACC_W-1:0] integ  [CH];
  logic signed [E_W-1:0]   prev_e [CH];
  logic [CH-1:0]           sat_hi_r;
  logic [CH-1:0]           sat_lo_r;

  logic s1_v;
  logic s2_v;
  s1_t  s1;
  s2_t  s2;
  s2_t  prod;

  logic                    in_range;
  logic                    clr_range;
  logic                    accept;
  logic [CH_W-1:0]         idx;
  logic [CH_W-1:0]         clr_idx;
  logic signed [E_W-1:0]   e;
  logic signed [D_W-1:0]   d;
  logic                    hold;
  wide_t                   i_sum;
  logic signed [ACC_W-1:0] i_new;
  logic signed [SUM_W-1:0] sum;
  logic signed [WIDTH-1:0] sat_val;
  logic                    sat_hi;
  logic                    sat_lo;

  // Out-of-range indices are steered to entry 0 for reads and never written.
  assign in_range  = {1'b0, in_ch} < CH_LIM;
  assign clr_range = {1'b0, clear_ch} < CH_LIM;
  assign idx       = in_range ? in_ch : '0;
  assign clr_idx   = clr_range ? clear_ch : '0;

  assign in_ready = !((s1_v && s1.ch == in_ch) || (s2_v && s2.ch == in_ch));
  assign accept   = in_valid && in_ready;

  always_comb begin
    e     = E_W'(setpoint) - E_W'(feedback);
    d     = D_W'(e) - D_W'(prev_e[idx]);
    // Stop integrating further into a rail the last result already hit.
    hold  = (sat_hi_r[idx] && !e[E_W-1] && (e != '0)) || (sat_lo_r[idx] && e[E_W-1]);
    i_sum = wide_t'(integ[idx]) + wide_t'(e);
    i_new = hold ? integ[idx] : ACC_W'(sat_clamp(i_sum, wide_t'(INT_LIM)));
  end

  always_comb begin
    prod.ch = s1.ch;
    prod.p  = PE_W'($signed(s1.kp)) * PE_W'($signed(s1.e));
    prod.i  = PI_W'($signed(s1.ki)) * PI_W'($signed(s1.i));
    prod.d  = PD_W'($signed(s1.kd)) * PD_W'($signed(s1.d));
    sum     = SUM_W'($signed(s2.p)) + SUM_W'($signed(s2.i)) + SUM_W'($signed(s2.d));
  end

  pid_sat #(
    .IN_W  (SUM_W),
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .MAX_V (out_max(WIDTH)),
    .MIN_V (out_min(WIDTH))
  ) u_sat (
    .sum    (sum),
    .result (sat_val),
    .sat_hi (sat_hi),
    .sat_lo (sat_lo)
  );

  // Pipeline payload carries no reset; the valids qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1 <= '{ch: in_ch, e: e, i: i_new, d: d, kp: kp, ki: ki, kd: kd};
    end
    s2 <= prod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      control_out <= '0;
      out_sat     <= '0;
      sat_hi_r    <= '0;
      sat_lo_r    <= '0;
      for (int c = 0; c < CH; c++) begin
        integ[c]  <= '0;
        prev_e[c] <= '0;
      end
    end else begin
      s1_v      <= accept && in_range;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (s2_v) begin
        out_ch            <= s2.ch;
        control_out       <= sat_val;
        out_sat           <= {sat_hi, sat_lo};
        sat_hi_r[s2.ch]   <= sat_hi;
        sat_lo_r[s2.ch]   <= sat_lo;
      end
      if (accept && in_range) begin
        integ[idx]  <= i_new;
        prev_e[idx] <= e;
      end
      // Clear is last so it overrides any same-edge write to the channel.
      if (clear_en && clr_range) begin
        integ[clr_idx]    <= '0;
        prev_e[clr_idx]   <= '0;
        sat_hi_r[clr_idx] <= 1'b0;
        sat_lo_r[clr_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: doc/pid_controller_mc.md
Name: pid_controller_mc

Overview:
Multi-channel, time-multiplexed discrete PID controller. It is the next generation of the single-channel integer PID and adds the following:
- runtime fixed-point gains
- a clamped integrator with conditional-integration anti-windup
- output saturation
- a valid/ready sample interface

One 3-stage arithmetic pipeline serves CH control loops. Per-channel state is held in register arrays.

Parameters:
WIDTH, 16, signed width of setpoint/feedback/control_out
CH, 4, number of channels (≥1)
GAIN_W, 16, signed gain width
FRAC, 8, gain fractional bits (Q(GAIN_W-FRAC).FRAC)
ACC_W, 32, signed integrator width
INT_LIM, 2**20, integrator clamp magnitude (0 < INT_LIM < 2**(ACC_W-1))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  sample offered
in_ready  out  1  sample can be accepted (combinational)
in_ch  in  CH_W  channel index, CH_W = max(1,clog2(CH))
setpoint  in  WIDTH  signed target
feedback  in  WIDTH  signed measurement
kp, ki, kd  in  GAIN_W each  signed gains, sampled with the sample
clear_en  in  1  clear state of clear_ch this cycle
clear_ch  in  CH_W  channel to clear
out_valid  out  1  one-cycle result strobe
out_ch  out  CH_W  channel of result
control_out  out  WIDTH  signed saturated output
out_sat  out  2  {hi,lo} saturation flags for this result

Behaviour:
- Accept: in_valid && in_ready at rising edge t. Result has out_valid=1 in the cycle after edge t+2 (latency 3). Throughput is 1 sample/cycle across distinct channels. There is no output backpressure.
- in_ready = !((s1_v && s1_ch==in_ch) || (s2_v && s2_ch==in_ch)). This interlock prevents a same-channel read-after-write hazard. A channel can be re-accepted at edge t+3 at the earliest.
- Out-of-range in_ch (≥CH) is accepted and discarded: no state change, no output.
- Stage 0 (edge t):
  - e = sp − fb, computed in WIDTH+1 bits.
  - d = e − prev_e[ch], computed in WIDTH+2 bits.
  - Anti-windup: hold = (sat_hi[ch] && e>0) || (sat_lo[ch] && e<0).
  - i_new = hold ? I[ch] : clamp(I[ch]+e, ±INT_LIM).
  - Commit I[ch] ← i_new and prev_e[ch] ← e.
  - Register e, i_new, d, gains, ch.
- Stage 1 (edge t+1): register signed products kp·e, ki·i_new, kd·d at full width.
- Stage 2 (edge t+2):
  - Sum in ACC_W+GAIN_W+2 bits.
  - Arithmetic shift right FRAC (floor).
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Set out_sat and write sat_hi/sat_lo[ch].
- clear_en: on the edge, I, prev_e and sat flags of clear_ch go to 0. If a sample for the same channel is accepted on that edge, the clear wins for stored state. The sample computes from the pre-clear state and its stage-2 sat write is still applied. In-flight results are not cancelled.
- Reset, including mid-operation: all channel state is 0 and pipeline valids are 0, so in-flight samples are dropped. Outputs reset to out_valid=0, out_ch=0, control_out=0, out_sat=0. in_ready=1 in the first cycle after reset.
- Gains are per-sample. Changing gains does not disturb stored state.

Decomposition:
- Package pid_pkg holds:
  - the CH_W computation
  - a signed saturate/clamp function (value, limit)
  - localparams for the output MIN/MAX derived from WIDTH
- Sub-module pid_sat: combinational floor-shift-then-saturate of the wide sum to WIDTH, producing hi/lo flags. It is reused by future single-channel variants.

Test Plan:
1. P only: CH=4, ch1, kp=256 (1.0), ki=kd=0, sp=100, fb=0 → control_out=100 with out_ch=1 exactly 3 cycles after accept, out_sat=00.
2. Integral: ch0, kp=kd=0, ki=256, error 10 for 3 spaced samples → outputs 10, 20, 30. Then clear_en on ch0 and error 10 → 10.
3. Derivative: ch2, kd=256, kp=ki=0, errors 0 then 50 then 50 → outputs 0, 50, 0.
4. Saturation/anti-windup: ch3, kp=512 (2.0), ki=256, sp=30000, fb=−30000 → control_out=32767, out_sat=10. A second identical sample holds I at 60000 (not 120000). sp=fb=0 with kp=0 → control_out=32767. sp=0, fb=20000 → control_out=32767 from I=40000 (integrates down, e<0).
5. Interlock and interleave: in_valid held with ch sequence 0,1,2,3,0,0 → first five accepted on consecutive edges. The sixth (ch0) sees in_ready=0 for 2 cycles. Results appear in order with correct out_ch; in_ch=5 with CH=4 produces no output.
6. Reset mid-operation: assert reset 1 cycle with 2 samples in flight → no out_valid afterwards, and the next sample on a previously integrating channel shows I restarted from 0.
